// File: rtl/hdmi_line_doubler_if.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_line_doubler_if
//  Description : Source pixel stream from the VDP into the line doubler.
//                The source drives through the master modport; the doubler
//                consumes through the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hdmi_line_doubler_if;
    logic        src_valid;
    logic        src_line_start;
    logic [23:0] src_rgb;
    logic        src_hires;

    modport master (
        output src_valid,
        output src_line_start,
        output src_rgb,
        output src_hires
    );

    modport slave (
        input  src_valid,
        input  src_line_start,
        input  src_rgb,
        input  src_hires
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_line_doubler.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_line_doubler
//  Description : Ping-pong line buffer and scan doubler feeding the HDMI
//                encoder. Each source line is shown on two output rows,
//                centred in the 640x480 active area; border colour elsewhere.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_line_doubler #(
    parameter int SRC_WIDTH = 512,
    parameter int X_OFFSET  = 64,
    parameter int Y_OFFSET  = 0,
    parameter int SRC_LINES = 240
) (
    input  wire logic               clk_pixel,
    input  wire logic               reset_n,
    hdmi_line_doubler_if.slave      src,
    input  wire logic [23:0]        border_rgb,
    input  wire logic [10:0]        nx,
    input  wire logic [9:0]         ny,
    output logic      [23:0]        rgb,
    output logic                    underrun,
    output logic                    overflow
);

    localparam int                   c_addr_w  = $clog2(SRC_WIDTH);
    localparam logic [c_addr_w-1:0]  c_last_hi = c_addr_w'(SRC_WIDTH - 1);
    localparam logic [c_addr_w-1:0]  c_last_lo = c_addr_w'(SRC_WIDTH / 2 - 1);

    // Line storage: bank index is the MSB of the flat address.
    logic [23:0]         r_mem [0:2*SRC_WIDTH-1];
    logic [1:0]          r_bank_hires;

    logic                r_rbank;
    logic                r_rvalid;
    logic [1:0]          r_full;
    logic [c_addr_w-1:0] r_wptr;
    logic                r_wactive;

    logic                w_wbank;
    logic                w_tgt_full;
    logic                w_start;
    logic                w_cont;
    logic                w_drop;
    logic                w_wr_en;
    logic [c_addr_w-1:0] w_wr_addr;
    logic [c_addr_w-1:0] w_last;
    logic                w_done;
    logic [10:0]         w_ny_rel;
    logic [11:0]         w_x;
    logic                w_in_rows;
    logic                w_in_cols;
    logic                w_swap_pt;
    logic                w_swap;
    logic                w_rd_bank;
    logic                w_rd_hires;
    logic [c_addr_w-1:0] w_rd_addr;
    logic                w_rd_valid;

    // Write-side decode: the writer only ever touches the bank not on display.
    always_comb begin
        w_wbank    = ~r_rbank;
        w_tgt_full = r_full[w_wbank];
        w_start    = src.src_valid & src.src_line_start & ~w_tgt_full;
        // A bank is only marked full as wactive drops, so a continuing
        // write never targets a full bank.
        w_cont     = src.src_valid & r_wactive & ~src.src_line_start;
        w_drop     = src.src_valid & ~w_start & ~w_cont;
        w_wr_en    = w_start | w_cont;
        w_wr_addr  = w_start ? '0 : r_wptr;
        w_last     = r_bank_hires[w_wbank] ? c_last_hi : c_last_lo;
        w_done     = w_cont & (r_wptr == w_last);
    end

    // Raster decode: offsets subtracted with wrap so left/above the window
    // lands far above the window size and fails the single compare.
    always_comb begin
        w_ny_rel   = {1'b0, ny} - 11'(Y_OFFSET);
        w_x        = {1'b0, nx} - 12'(X_OFFSET);
        w_in_rows  = (w_ny_rel < 11'(2 * SRC_LINES));
        w_in_cols  = (w_x < 12'(SRC_WIDTH));
        w_swap_pt  = (nx == 11'd0) & w_in_rows & ~w_ny_rel[0];
        // A line finishing in this very cycle is good enough to swap in.
        w_swap     = w_swap_pt & (w_tgt_full | w_done);
        // Read through the bank that will be on display after this edge.
        w_rd_bank  = w_swap ? ~r_rbank : r_rbank;
        w_rd_hires = r_bank_hires[w_rd_bank];
        w_rd_addr  = w_rd_hires ? w_x[c_addr_w-1:0] : w_x[c_addr_w:1];
        w_rd_valid = r_rvalid | w_swap;
    end

    // Line RAM write port.
    always_ff @(posedge clk_pixel) begin
        if (w_wr_en) begin
            r_mem[{w_wbank, w_wr_addr}] <= src.src_rgb;
        end
    end

    // Writer pointer, line-active flag and per-bank resolution flag.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr       <= '0;
            r_wactive    <= 1'b0;
            r_bank_hires <= 2'b00;
        end else if (w_start) begin
            r_wptr                <= c_addr_w'(1);
            r_wactive             <= 1'b1;
            r_bank_hires[w_wbank] <= src.src_hires;
        end else if (w_cont) begin
            r_wptr <= r_wptr + c_addr_w'(1);
            if (w_done) begin
                r_wactive <= 1'b0;
            end
        end
    end

    // Bank ownership: full flags, displayed bank and first-line-seen flag.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_full   <= 2'b00;
            r_rbank  <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_done) begin
                r_full[w_wbank] <= 1'b1;
            end
            // Handing the finished bank to the reader clears its full flag,
            // overriding a completion in the same cycle.
            if (w_swap) begin
                r_full[w_wbank] <= 1'b0;
                r_rbank         <= ~r_rbank;
                r_rvalid        <= 1'b1;
            end
        end
    end

    // Registered pixel output and status pulses, aligned with cx/cy.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            rgb      <= 24'd0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rgb      <= (w_in_rows & w_in_cols & w_rd_valid)
                        ? r_mem[{w_rd_bank, w_rd_addr}] : border_rgb;
            underrun <= w_swap_pt & ~w_swap;
            overflow <= w_drop;
        end
    end

endmodule
`default_nettype wire
